// File: rtl/reset_sequencer_pkg.sv
// Shared types and default constants for the reset sequencer.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    SEQ       = 2'd2,
    DONE      = 2'd3
  } rst_seq_state_t;

  localparam int unsigned DEF_NUM_STAGES   = 3;
  localparam int unsigned DEF_SYNC_STAGES  = 2;
  localparam int unsigned DEF_STAGE_DLY    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT = 1024;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Lock/request inputs and sequenced reset outputs of the reset sequencer.
// lock_timeout_o exists only when RESET_SEQUENCER_WATCHDOG_EN is defined.
interface reset_sequencer_if #(
  parameter int unsigned NUM_STAGES = 3
);
  logic                  locked_i;
  logic                  sw_rst_i;
  logic [NUM_STAGES-1:0] rst_n_o;
  logic                  rst_done_o;
  logic                  busy_o;
`ifdef RESET_SEQUENCER_WATCHDOG_EN
  logic                  lock_timeout_o;
`endif

  modport master (
    output locked_i, sw_rst_i,
`ifdef RESET_SEQUENCER_WATCHDOG_EN
    input  lock_timeout_o,
`endif
    input  rst_n_o, rst_done_o, busy_o
  );

  modport slave (
    input  locked_i, sw_rst_i,
`ifdef RESET_SEQUENCER_WATCHDOG_EN
    output lock_timeout_o,
`endif
    output rst_n_o, rst_done_o, busy_o
  );
endinterface

// File: rtl/reset_sequencer_rst_sync.sv
// Async-clear flop chain: with d_i tied high it is a reset synchronizer
// (async assert, sync deassert); with a data input it is a plain CDC synchronizer.
module rst_sync #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], d_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q_o = sync_q[DEPTH-1];
endmodule

// File: rtl/reset_sequencer.sv
// Ordered release of NUM_STAGES reset domains after clock lock, with lock-loss
// and software reassertion. Optional lock watchdog: RESET_SEQUENCER_WATCHDOG_EN.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned NUM_STAGES   = DEF_NUM_STAGES,
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned STAGE_DLY    = DEF_STAGE_DLY,
  parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  reset_sequencer_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(max_u(STAGE_DLY, LOCK_TIMEOUT));
  localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic rst_int_n;
  logic locked_s;

  rst_sync #(.DEPTH(SYNC_STAGES)) u_rst_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (1'b1),
    .q_o   (rst_int_n)
  );

  rst_sync #(.DEPTH(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.locked_i),
    .q_o   (locked_s)
  );

  rst_seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
`ifdef RESET_SEQUENCER_WATCHDOG_EN
  logic                  tmo_q, tmo_d;
`endif

  // Next state: software request beats lock loss beats normal progression.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
`ifdef RESET_SEQUENCER_WATCHDOG_EN
    tmo_d   = tmo_q;
`endif
    if (bus.sw_rst_i) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
    end else if (!locked_s && (state_q == SEQ || state_q == DONE)) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == CNT_W'(STAGE_DLY - 1)) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = SEQ;
            cnt_d   = '0;
            idx_d   = '0;
`ifdef RESET_SEQUENCER_WATCHDOG_EN
            tmo_d   = 1'b0;
          end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            tmo_d   = 1'b1;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
`endif
          end
        end
        SEQ: begin
          if (cnt_q == CNT_W'(STAGE_DLY - 1)) begin
            cnt_d   = '0;
            // Shifting in a one keeps released domains a contiguous low-order run.
            rst_n_d = NUM_STAGES'({rst_n_q, 1'b1});
            if (idx_q == IDX_W'(NUM_STAGES - 1)) state_d = DONE;
            else                                 idx_d   = idx_q + IDX_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_d = DONE;
        default: state_d = WAIT_LOCK;
      endcase
    end
    done_d = (state_d == DONE);
    busy_d = (state_d != DONE);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
`ifdef RESET_SEQUENCER_WATCHDOG_EN
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef RESET_SEQUENCER_WATCHDOG_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign bus.rst_n_o    = rst_n_q;
  assign bus.rst_done_o = done_q;
  assign bus.busy_o     = busy_q;
`ifdef RESET_SEQUENCER_WATCHDOG_EN
  assign bus.lock_timeout_o = tmo_q;
`endif
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (NUM_STAGES=3, SYNC_STAGES=2, STAGE_DLY=16).
// Watchdog scenario runs only when RESET_SEQUENCER_WATCHDOG_EN is defined.
module tb_reset_sequencer;
  import reset_sequencer_pkg::*;

  localparam int unsigned NS  = 3;
  localparam int unsigned DLY = 16;
`ifdef RESET_SEQUENCER_WATCHDOG_EN
  localparam int unsigned TMO = 64;
`else
  localparam int unsigned TMO = DEF_LOCK_TIMEOUT;
`endif
  localparam logic [NS-1:0] ALL = '1;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors     = 0;
  int   miscompares = 0;

  reset_sequencer_if #(.NUM_STAGES(NS)) bus ();

  reset_sequencer #(
    .NUM_STAGES   (NS),
    .SYNC_STAGES  (2),
    .STAGE_DLY    (DLY),
    .LOCK_TIMEOUT (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Released pattern e edges into a run whose bit 0 releases on edge 'base'.
  function automatic logic [NS-1:0] exp_rst(input int e, input int base);
    int n;
    n = 0;
    for (int k = 0; k < int'(NS); k++)
      if (e >= base + k * int'(DLY)) n = k + 1;
    return NS'((1 << n) - 1);
  endfunction

  task automatic hold_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.locked_i = 1'b1;
    bus.sw_rst_i = 1'b0;
    repeat (3) tick();
    vectors++;
    if (bus.rst_n_o !== 3'b000 || bus.rst_done_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset: rst_n_o=%b done=%b busy=%b, expected 000/0/1",
               bus.rst_n_o, bus.rst_done_o, bus.busy_o);
    end
  endtask

  task automatic test_powerup();
    logic [NS-1:0] exp;
    rst_n = 1'b1;
    for (int e = 1; e <= 56; e++) begin
      tick();
      exp = exp_rst(e, 19);
      vectors++;
      if (bus.rst_n_o !== exp || bus.rst_done_o !== (exp == ALL) || bus.busy_o !== (exp != ALL)) begin
        miscompares++;
        $display("FAIL powerup e=%0d: rst_n_o=%b done=%b busy=%b, expected %b",
                 e, bus.rst_n_o, bus.rst_done_o, bus.busy_o, exp);
      end
    end
  endtask

  task automatic test_lock_loss();
    logic [NS-1:0] exp;
    bus.locked_i = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      exp = (e < 3) ? ALL : '0;
      vectors++;
      if (bus.rst_n_o !== exp || bus.busy_o !== (exp != ALL)) begin
        miscompares++;
        $display("FAIL lock_loss e=%0d: rst_n_o=%b busy=%b, expected %b",
                 e, bus.rst_n_o, bus.busy_o, exp);
      end
    end
    bus.locked_i = 1'b1;
    for (int e = 1; e <= 56; e++) begin
      tick();
      exp = exp_rst(e, 19);
      vectors++;
      if (bus.rst_n_o !== exp || bus.rst_done_o !== (exp == ALL)) begin
        miscompares++;
        $display("FAIL relock e=%0d: rst_n_o=%b done=%b, expected %b",
                 e, bus.rst_n_o, bus.rst_done_o, exp);
      end
    end
  endtask

  task automatic test_sw_rst();
    logic [NS-1:0] exp;
    bus.sw_rst_i = 1'b1;
    for (int e = 1; e <= 70; e++) begin
      tick();
      if (e == 1) bus.sw_rst_i = 1'b0;
      exp = exp_rst(e, 34);
      vectors++;
      if (bus.rst_n_o !== exp || bus.rst_done_o !== (exp == ALL) || bus.busy_o !== (exp != ALL)) begin
        miscompares++;
        $display("FAIL sw_rst e=%0d: rst_n_o=%b done=%b busy=%b, expected %b",
                 e, bus.rst_n_o, bus.rst_done_o, bus.busy_o, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [NS-1:0] exp;
    bus.sw_rst_i = 1'b1;
    for (int e = 1; e <= 74; e++) begin
      tick();
      if (e == 1) bus.sw_rst_i = 1'b0;
      if (e == 4) bus.sw_rst_i = 1'b1;
      if (e == 5) bus.sw_rst_i = 1'b0;
      exp = exp_rst(e, 38);
      vectors++;
      if (bus.rst_n_o !== exp || bus.rst_done_o !== (exp == ALL)) begin
        miscompares++;
        $display("FAIL back_to_back e=%0d: rst_n_o=%b done=%b, expected %b",
                 e, bus.rst_n_o, bus.rst_done_o, exp);
      end
    end
  endtask

  task automatic test_async_abort();
    logic [NS-1:0] exp;
    hold_reset();
    for (int e = 1; e <= 27; e++) begin
      tick();
      exp = exp_rst(e, 19);
      vectors++;
      if (bus.rst_n_o !== exp) begin
        miscompares++;
        $display("FAIL abort_pre e=%0d: rst_n_o=%b, expected %b", e, bus.rst_n_o, exp);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.rst_n_o !== 3'b000 || bus.rst_done_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_async: rst_n_o=%b done=%b busy=%b, expected 000/0/1",
               bus.rst_n_o, bus.rst_done_o, bus.busy_o);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 56; e++) begin
      tick();
      exp = exp_rst(e, 19);
      vectors++;
      if (bus.rst_n_o !== exp || bus.rst_done_o !== (exp == ALL)) begin
        miscompares++;
        $display("FAIL abort_restart e=%0d: rst_n_o=%b done=%b, expected %b",
                 e, bus.rst_n_o, bus.rst_done_o, exp);
      end
    end
  endtask

  task automatic test_lock_wait();
    logic [NS-1:0] exp;
    bus.locked_i = 1'b0;
    hold_reset();
    for (int e = 1; e <= 200; e++) begin
      tick();
      vectors++;
      if (bus.rst_n_o !== 3'b000 || bus.busy_o !== 1'b1 || bus.rst_done_o !== 1'b0) begin
        miscompares++;
        $display("FAIL lock_wait e=%0d: rst_n_o=%b busy=%b done=%b, expected 000/1/0",
                 e, bus.rst_n_o, bus.busy_o, bus.rst_done_o);
      end
    end
    bus.locked_i = 1'b1;
    for (int e = 1; e <= 56; e++) begin
      tick();
      exp = exp_rst(e, 19);
      vectors++;
      if (bus.rst_n_o !== exp || bus.busy_o !== (exp != ALL)) begin
        miscompares++;
        $display("FAIL lock_late e=%0d: rst_n_o=%b busy=%b, expected %b",
                 e, bus.rst_n_o, bus.busy_o, exp);
      end
    end
  endtask

`ifdef RESET_SEQUENCER_WATCHDOG_EN
  task automatic test_watchdog();
    logic exp_t;
    bus.locked_i = 1'b0;
    hold_reset();
    for (int e = 1; e <= 70; e++) begin
      tick();
      exp_t = (e >= 66);
      vectors++;
      if (bus.lock_timeout_o !== exp_t || bus.rst_n_o !== 3'b000) begin
        miscompares++;
        $display("FAIL watchdog e=%0d: lock_timeout_o=%b rst_n_o=%b, expected %b/000",
                 e, bus.lock_timeout_o, bus.rst_n_o, exp_t);
      end
    end
    bus.locked_i = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      exp_t = (e < 3);
      vectors++;
      if (bus.lock_timeout_o !== exp_t) begin
        miscompares++;
        $display("FAIL watchdog_clear e=%0d: lock_timeout_o=%b, expected %b",
                 e, bus.lock_timeout_o, exp_t);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_powerup();
    test_lock_loss();
    test_sw_rst();
    test_back_to_back();
    test_async_abort();
    test_lock_wait();
`ifdef RESET_SEQUENCER_WATCHDOG_EN
    test_watchdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
